// File: rtl/cpu_mem_loader.sv
// Host-side loader: streams words into CPU instruction/data memories, runs the CPU, dumps data memory.
// Optional LOADER_CHECKSUM_EN adds a mod-2^32 sum of all accepted input beats on port checksum.
module cpu_mem_loader #(
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_words,
  input  logic [CNT_W-1:0] dmem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum
`endif
);

  localparam int AW   = CNT_W + 3;
  localparam int WT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_I, S_LOAD_DL, S_LOAD_DH, S_RUN,
    S_DUMP_RD, S_DUMP_WT, S_DUMP_LO, S_DUMP_HI
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] dmem_n_q, run_n_q, dump_n_q, cnt_q;
  logic [AW-1:0]    iaddr_q, daddr_q;
  logic [31:0]      low_q;
  logic [63:0]      hold_q;
  logic [WT_W-1:0]  wt_q;
  logic             done_q;

  state_e after_i, after_d, after_r;

  // Phases with a zero count are skipped, so the successor of each phase is the next non-empty one.
  always_comb begin
    after_r = (dump_n_q != '0) ? S_DUMP_RD : S_IDLE;
    after_d = (run_n_q  != '0) ? S_RUN     : after_r;
    after_i = (dmem_n_q != '0) ? S_LOAD_DL : after_d;
  end

  function automatic logic [CNT_W-1:0] phase_cnt(input state_e s, input logic [CNT_W-1:0] dm,
                                                 input logic [CNT_W-1:0] rn, input logic [CNT_W-1:0] dp);
    case (s)
      S_LOAD_DL: return dm;
      S_RUN:     return rn;
      S_DUMP_RD: return dp;
      default:   return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= S_IDLE;
      dmem_n_q <= '0;
      run_n_q  <= '0;
      dump_n_q <= '0;
      cnt_q    <= '0;
      iaddr_q  <= '0;
      daddr_q  <= '0;
      low_q    <= '0;
      hold_q   <= '0;
      wt_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          dmem_n_q <= dmem_words;
          run_n_q  <= run_cycles;
          dump_n_q <= dump_words;
          cnt_q    <= imem_words;
          iaddr_q  <= '0;
          daddr_q  <= '0;
          state_q  <= S_LOAD_I;
        end
        S_LOAD_I: begin
          if (cnt_q == '0 || (in_valid && cnt_q == CNT_W'(1))) begin
            state_q <= after_i;
            cnt_q   <= phase_cnt(after_i, dmem_n_q, run_n_q, dump_n_q);
            done_q  <= (after_i == S_IDLE);
          end else if (in_valid) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
          if (in_valid && cnt_q != '0) iaddr_q <= iaddr_q + AW'(4);
        end
        S_LOAD_DL: if (in_valid) begin
          low_q   <= in_data;
          state_q <= S_LOAD_DH;
        end
        S_LOAD_DH: if (in_valid) begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= after_d;
            cnt_q   <= phase_cnt(after_d, dmem_n_q, run_n_q, dump_n_q);
            done_q  <= (after_d == S_IDLE);
            daddr_q <= '0;
          end else begin
            state_q <= S_LOAD_DL;
            cnt_q   <= cnt_q - CNT_W'(1);
            daddr_q <= daddr_q + AW'(8);
          end
        end
        S_RUN: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= after_r;
            cnt_q   <= phase_cnt(after_r, dmem_n_q, run_n_q, dump_n_q);
            done_q  <= (after_r == S_IDLE);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DUMP_RD: begin
          state_q <= S_DUMP_WT;
          wt_q    <= WT_W'(RD_LAT - 1);
        end
        S_DUMP_WT: begin
          if (wt_q == '0) begin
            hold_q  <= rdata_ext_2;
            state_q <= S_DUMP_LO;
          end else begin
            wt_q <= wt_q - WT_W'(1);
          end
        end
        S_DUMP_LO: if (out_ready) state_q <= S_DUMP_HI;
        S_DUMP_HI: if (out_ready) begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_DUMP_RD;
            cnt_q   <= cnt_q - CNT_W'(1);
            daddr_q <= daddr_q + AW'(8);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write strobes follow the handshake combinationally so each beat lands in its own cycle.
  assign in_ready    = (state_q == S_LOAD_I && cnt_q != '0) || state_q == S_LOAD_DL || state_q == S_LOAD_DH;
  assign wen_ext     = (state_q == S_LOAD_I) && (cnt_q != '0) && in_valid;
  assign wdata_ext   = wen_ext ? in_data : '0;
  assign addr_ext    = 64'(iaddr_q);
  assign wen_ext_2   = (state_q == S_LOAD_DH) && in_valid;
  assign wdata_ext_2 = wen_ext_2 ? {in_data, low_q} : '0;
  assign ren_ext_2   = (state_q == S_DUMP_RD);
  assign addr_ext_2  = 64'(daddr_q);
  assign cpu_enable  = (state_q == S_RUN);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign out_valid   = (state_q == S_DUMP_LO) || (state_q == S_DUMP_HI);
  assign out_data    = (state_q == S_DUMP_LO) ? hold_q[31:0] :
                       (state_q == S_DUMP_HI) ? hold_q[63:32] : '0;
  assign out_last    = (state_q == S_DUMP_HI) && (cnt_q == CNT_W'(1));

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q;
  always_ff @(posedge clk) begin
    if (!arst_n)                        csum_q <= '0;
    else if (state_q == S_IDLE && start) csum_q <= '0;
    else if (in_valid && in_ready)      csum_q <= csum_q + in_data;
  end
  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: directed sessions plus randomized sessions against a queue-based reference.
module tb_cpu_mem_loader;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             arst_n, start, in_valid, in_ready, out_valid, out_ready, out_last;
  logic             busy, done, cpu_enable, wen_ext, wen_ext_2, ren_ext_2;
  logic [CNT_W-1:0] imem_words, dmem_words, run_cycles, dump_words;
  logic [31:0]      in_data, out_data, wdata_ext;
  logic [63:0]      addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]      checksum;
`endif

  cpu_mem_loader #(.CNT_W(CNT_W), .RD_LAT(1)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words), .run_cycles(run_cycles), .dump_words(dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE0000 | 32'(i), 32'h0BAD0000 | 32'(i)};
  endfunction

  // Data memory attached to the DUT, one read cycle of latency.
  logic [63:0] mem [64];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      rdata_ext_2 <= '0;
    end else begin
      if (wen_ext_2) mem[addr_ext_2[8:3]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[8:3]];
    end
  end

  int out_mode;
  always @(posedge clk) begin
    #1;
    case (out_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
  typedef struct { logic [31:0] d; logic l; } ob_t;
  wr_t         exp_iw[$];
  wr_t         exp_dw[$];
  logic [63:0] exp_ren[$];
  ob_t         exp_out[$];
  logic [63:0] ref_mem [64];
  logic [31:0] beat_q[$];

  int          run_cnt, run_seg, done_cnt;
  logic        stall_q, en_prev, prev_last;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    wr_t e;
    ob_t o;
    logic [63:0] ra;
    if (!arst_n) begin
      stall_q = 1'b0;
      en_prev = 1'b0;
    end else begin
      if (cpu_enable) check("en_vs_strobe", 64'({wen_ext, wen_ext_2, ren_ext_2}), 64'(0));
      if (wen_ext_2) check("wen_vs_ren", 64'(ren_ext_2), 64'(0));
      if (wen_ext) begin
        if (exp_iw.size() == 0) check("imem_unexpected", 64'(1), 64'(0));
        else begin
          e = exp_iw.pop_front();
          check("imem_addr", addr_ext, e.a);
          check("imem_data", 64'(wdata_ext), e.d);
        end
      end
      if (wen_ext_2) begin
        if (exp_dw.size() == 0) check("dmem_unexpected", 64'(1), 64'(0));
        else begin
          e = exp_dw.pop_front();
          check("dmem_addr", addr_ext_2, e.a);
          check("dmem_data", wdata_ext_2, e.d);
        end
      end
      if (ren_ext_2) begin
        if (exp_ren.size() == 0) check("ren_unexpected", 64'(1), 64'(0));
        else begin
          ra = exp_ren.pop_front();
          check("ren_addr", addr_ext_2, ra);
        end
      end
      if (stall_q) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) check("out_unexpected", 64'(1), 64'(0));
        else begin
          o = exp_out.pop_front();
          check("out_data", 64'(out_data), 64'(o.d));
          check("out_last", 64'(out_last), 64'(o.l));
        end
      end
      stall_q   = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (cpu_enable) begin
        run_cnt++;
        if (!en_prev) run_seg++;
      end
      en_prev = cpu_enable;
      if (done) done_cnt++;
    end
  end

  bit in_rand;

  task automatic session(input int im, input int dm, input int rc, input int dw, output int done_cyc);
    int n, idx, cyc;
    bit fin;
    logic [31:0] sum;
    logic [63:0] w;
    n = im + 2 * dm;
    sum = '0;
    for (int k = 0; k < n; k++) sum += beat_q[k];
    for (int k = 0; k < im; k++) exp_iw.push_back('{64'(4 * k), 64'(beat_q[k])});
    for (int k = 0; k < dm; k++) begin
      w = {beat_q[im + 2*k + 1], beat_q[im + 2*k]};
      ref_mem[k] = w;
      exp_dw.push_back('{64'(8 * k), w});
    end
    for (int j = 0; j < dw; j++) begin
      exp_ren.push_back(64'(8 * j));
      exp_out.push_back('{ref_mem[j][31:0], 1'b0});
      exp_out.push_back('{ref_mem[j][63:32], 1'(j == dw - 1)});
    end
    run_cnt = 0; run_seg = 0; done_cnt = 0;
    imem_words = CNT_W'(im); dmem_words = CNT_W'(dm);
    run_cycles = CNT_W'(rc); dump_words = CNT_W'(dw);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    idx = 0; cyc = 0; fin = 0; done_cyc = -1;
    while (!fin && cyc < 2000) begin
      if (idx < n) begin
        in_valid = in_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_data  = beat_q[idx];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end
      @(negedge clk);
      cyc++;
      if (in_valid && in_ready) idx++;
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        check("busy_at_done", 64'(busy), 64'(0));
      end else begin
        check("busy_during", 64'(busy), 64'(1));
        @(posedge clk); #1;
      end
    end
    if (!fin) check("session_timeout", 64'(fin), 64'(1));
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("beats_used", 64'(idx), 64'(n));
    check("imem_pending", 64'(exp_iw.size()), 64'(0));
    check("dmem_pending", 64'(exp_dw.size()), 64'(0));
    check("ren_pending", 64'(exp_ren.size()), 64'(0));
    check("out_pending", 64'(exp_out.size()), 64'(0));
    check("run_len", 64'(run_cnt), 64'(rc));
    check("run_segments", 64'(run_seg), 64'(rc != 0));
    check("done_pulses", 64'(done_cnt), 64'(1));
`ifdef LOADER_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(sum));
`endif
    exp_iw.delete(); exp_dw.delete(); exp_ren.delete(); exp_out.delete();
    beat_q.delete();
  endtask

  initial begin
    int dc, cyc, im, dm;
    arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    imem_words = '0; dmem_words = '0; run_cycles = '0; dump_words = '0;
    out_mode = 0; in_rand = 0; init_mem = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_cpu_enable", 64'(cpu_enable), 64'(0));
    check("rst_strobes", 64'({wen_ext, wen_ext_2, ren_ext_2}), 64'(0));
    check("rst_addr_ext", addr_ext, 64'(0));
    check("rst_addr_ext_2", addr_ext_2, 64'(0));
    @(posedge clk); #1 arst_n = 1'b1; init_mem = 1'b0;

    beat_q = '{32'h00000013, 32'h00100093};
    session(2, 0, 0, 0, dc);

    beat_q = '{32'hDEADBEEF, 32'h01234567};
    session(0, 1, 0, 0, dc);
    check("dmem0_content", mem[0], 64'h01234567DEADBEEF);

    session(0, 0, 5, 1, dc);

    out_mode = 1;
    beat_q = '{32'h33334444, 32'h11112222, 32'h77778888, 32'h55556666};
    session(0, 2, 0, 2, dc);
    out_mode = 0;

    // Reset while a data word is half assembled.
    imem_words = '0; dmem_words = CNT_W'(1); run_cycles = '0; dump_words = '0;
    in_valid = 1'b1; in_data = 32'hCAFEF00D;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 10) begin @(negedge clk); cyc++; end
    check("reach_load_dl", 64'(cyc < 10), 64'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("dh_busy", 64'(busy), 64'(1));
    check("dh_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1 arst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_strobes", 64'({wen_ext, wen_ext_2, ren_ext_2, cpu_enable, in_ready, out_valid}), 64'(0));
    check("midrst_addr_ext_2", addr_ext_2, 64'(0));
    @(posedge clk); #1 arst_n = 1'b1;

    beat_q = '{$urandom, $urandom, $urandom};
    session(1, 1, 0, 1, dc);

    session(0, 0, 0, 0, dc);
    check("zero_done_latency", 64'(dc), 64'(2));

    out_mode = 2; in_rand = 1;
    for (int s = 0; s < 25; s++) begin
      im = $urandom_range(0, 4);
      dm = $urandom_range(0, 4);
      for (int k = 0; k < im + 2 * dm; k++) beat_q.push_back($urandom);
      session(im, dm, $urandom_range(0, 6), $urandom_range(0, 5), dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
